// File: rtl/uart_param_transceiver_pkg.sv
// Shared parity constants, Tx/Rx FSM encodings and the frame-length helper.
package uart_param_transceiver_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    function automatic int unsigned frame_bits(int unsigned dw, int unsigned par,
                                               int unsigned sb);
        return 1 + dw + ((par != PARITY_NONE) ? 1 : 0) + sb;
    endfunction

endpackage

// File: rtl/uart_param_transceiver_if.sv
// Host-side handshake and serial-pin bundle for uart_param_transceiver.
interface uart_param_transceiver_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_busy;
    logic                  serial_out;
    logic                  serial_in;
    logic [DATA_WIDTH-1:0] received_data;
    logic                  data_is_valid;
    logic                  parity_error;
    logic                  framing_error;

    modport master (
        output enable, i_data, serial_in,
        input  o_busy, serial_out, received_data, data_is_valid, parity_error, framing_error
    );

    modport slave (
        input  enable, i_data, serial_in,
        output o_busy, serial_out, received_data, data_is_valid, parity_error, framing_error
    );
endinterface

// File: rtl/uart_param_transceiver_bit_timer.sv
// Per-direction bit-period down-counter; tick is high while the count sits at zero.
module uart_param_transceiver_bit_timer #(
    parameter int unsigned CLOCKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic half,
    output logic tick
);
    localparam int unsigned CntW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLOCKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLOCKS_PER_BIT / 2 - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = half ? HalfLoad : FullLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/uart_param_transceiver.sv
// Full-duplex parametrised UART with independent Tx and Rx FSMs on one clock.
// Define UART_LOOPBACK_EN to feed the registered serial_out into the Rx synchronizer.
module uart_param_transceiver
    import uart_param_transceiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PARITY_TYPE    = 1,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned CLOCKS_PER_BIT = 8
) (
    input logic clk,
    input logic reset,
    uart_param_transceiver_if.slave bus
);
    localparam int unsigned FrameBits = frame_bits(DATA_WIDTH, PARITY_TYPE, STOP_BITS);
    localparam int unsigned BitCntW   = $clog2(FrameBits);
    // Bit counters hold the frame index of the bit currently on the line.
    localparam logic [BitCntW-1:0] LastDataIdx = BitCntW'(DATA_WIDTH);
    localparam logic [BitCntW-1:0] LastIdx     = BitCntW'(FrameBits - 1);
    localparam logic HasParity = (PARITY_TYPE == PARITY_EVEN) || (PARITY_TYPE == PARITY_ODD);
    localparam logic ParOdd    = (PARITY_TYPE == PARITY_ODD);

    tx_state_e             tx_state_q, tx_state_d;
    logic [BitCntW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  serial_out_q, serial_out_d;
    logic                  tx_load, tx_tick;

    rx_state_e             rx_state_q, rx_state_d;
    logic [BitCntW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_par_q, rx_par_d;
    logic                  valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                  sync1_q, sync2_q, rx_prev_q;
    logic                  rx_line, rx_par_bad, rx_load, rx_half, rx_tick;

    uart_param_transceiver_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_tx_timer (
        .clk(clk), .reset(reset), .load(tx_load), .half(1'b0), .tick(tx_tick)
    );

    uart_param_transceiver_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_rx_timer (
        .clk(clk), .reset(reset), .load(rx_load), .half(rx_half), .tick(rx_tick)
    );

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_shift_d   = tx_shift_q;
        tx_par_d     = tx_par_q;
        serial_out_d = serial_out_q;
        tx_load      = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                if (bus.enable) begin
                    tx_shift_d   = bus.i_data;
                    tx_par_d     = (^bus.i_data) ^ ParOdd;
                    serial_out_d = 1'b0;
                    tx_load      = 1'b1;
                    tx_state_d   = TxStart;
                end
            end
            TxStart, TxData: begin
                if (tx_tick) begin
                    tx_load  = 1'b1;
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == LastDataIdx) begin
                        serial_out_d = HasParity ? tx_par_q : 1'b1;
                        tx_state_d   = HasParity ? TxParity : TxStop;
                    end else begin
                        serial_out_d = tx_shift_q[0];
                        tx_shift_d   = tx_shift_q >> 1;
                        tx_state_d   = TxData;
                    end
                end
            end
            TxParity: begin
                if (tx_tick) begin
                    tx_load      = 1'b1;
                    tx_cnt_d     = tx_cnt_q + 1'b1;
                    serial_out_d = 1'b1;
                    tx_state_d   = TxStop;
                end
            end
            TxStop: begin
                if (tx_tick) begin
                    if (tx_cnt_q == LastIdx) begin
                        tx_cnt_d   = '0;
                        tx_state_d = TxIdle;
                    end else begin
                        tx_load  = 1'b1;
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

`ifdef UART_LOOPBACK_EN
    assign rx_line = serial_out_q;
`else
    assign rx_line = bus.serial_in;
`endif

    assign rx_par_bad = HasParity && (rx_par_q != ((^rx_shift_q) ^ ParOdd));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_par_d   = rx_par_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        rx_load    = 1'b0;
        rx_half    = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !sync2_q) begin
                    rx_load    = 1'b1;
                    rx_half    = 1'b1;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_tick) begin
                    if (sync2_q) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_load    = 1'b1;
                        rx_cnt_d   = rx_cnt_q + 1'b1;
                        rx_state_d = RxData;
                    end
                end
            end
            RxData: begin
                if (rx_tick) begin
                    rx_load    = 1'b1;
                    rx_cnt_d   = rx_cnt_q + 1'b1;
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_cnt_q == LastDataIdx) begin
                        rx_state_d = HasParity ? RxParity : RxStop;
                    end
                end
            end
            RxParity: begin
                if (rx_tick) begin
                    rx_load    = 1'b1;
                    rx_cnt_d   = rx_cnt_q + 1'b1;
                    rx_par_d   = sync2_q;
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                // Only the first stop bit is checked; Rx re-arms right after it.
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    perr_d     = rx_par_bad;
                    ferr_d     = !sync2_q;
                    valid_d    = sync2_q && !rx_par_bad;
                    if (sync2_q && !rx_par_bad) begin
                        rx_data_d = rx_shift_q;
                    end
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q   <= TxIdle;
            tx_cnt_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            serial_out_q <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_cnt_q     <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_par_q     <= 1'b0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            serial_out_q <= serial_out_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_par_q     <= rx_par_d;
            valid_q      <= valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            sync1_q      <= rx_line;
            sync2_q      <= sync1_q;
            rx_prev_q    <= sync2_q;
        end
    end

    assign bus.o_busy        = (tx_state_q != TxIdle);
    assign bus.serial_out    = serial_out_q;
    assign bus.received_data = rx_data_q;
    assign bus.data_is_valid = valid_q;
    assign bus.parity_error  = perr_q;
    assign bus.framing_error = ferr_q;
endmodule

// File: tb/tb_uart_param_transceiver.sv
// Self-checking bench: frame-level reference model, Rx vector table and random traffic.
module tb_uart_param_transceiver;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic reset;
    logic loop_mode;
    logic tb_rx;

    always #5 clk = ~clk;

    uart_param_transceiver_if #(.DATA_WIDTH(8)) bus ();
    uart_param_transceiver_if #(.DATA_WIDTH(7)) bus2 ();

    assign bus.serial_in  = loop_mode ? bus.serial_out : tb_rx;
    assign bus2.serial_in = bus2.serial_out;

    uart_param_transceiver #(
        .DATA_WIDTH(8), .PARITY_TYPE(1), .STOP_BITS(1), .CLOCKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    uart_param_transceiver #(
        .DATA_WIDTH(7), .PARITY_TYPE(2), .STOP_BITS(2), .CLOCKS_PER_BIT(CPB)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    typedef struct {
        logic       valid;
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_ev_t;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         exp_valid;
        bit         exp_perr;
        bit         exp_ferr;
    } rx_vec_t;

    rx_ev_t     ev_q[$];
    rx_ev_t     mon_e;
    rx_vec_t    vecs[7];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] last_good;
    logic [7:0] rd;
    bit         bp, bs;
    logic [15:0] fr2;
    logic [6:0]  d2;
    int          hold2, v2, err2;

    always @(negedge clk) begin
        if (bus.data_is_valid || bus.parity_error || bus.framing_error) begin
            mon_e.valid = bus.data_is_valid;
            mon_e.perr  = bus.parity_error;
            mon_e.ferr  = bus.framing_error;
            mon_e.data  = bus.received_data;
            ev_q.push_back(mon_e);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as a bit list: start 0, data LSB first, parity from the ones count, stops 1.
    function automatic logic [15:0] build_frame(input logic [8:0] data, input int dw,
                                                input int par);
        logic [15:0] f;
        int ones;
        f = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < dw; i++) begin
            f[1+i] = data[i];
            ones += int'(data[i]);
        end
        if (par == 1) f[1+dw] = 1'((ones % 2) != 0);
        else if (par == 2) f[1+dw] = 1'(((ones + 1) % 2) != 0);
        return f;
    endfunction

    // Call in a cycle with o_busy low; returns in the cycle o_busy falls.
    task automatic send_tx(input logic [7:0] data, input bit poke);
        logic [15:0] fr;
        int hold_err;
        fr = build_frame({1'b0, data}, 8, 1);
        bus.enable = 1'b1;
        bus.i_data = data;
        @(negedge clk);
        bus.enable = 1'b0;
        bus.i_data = ~data;
        hold_err = 0;
        for (int i = 0; i < 11 * CPB; i++) begin
            if (bus.o_busy !== 1'b1 || bus.serial_out !== fr[i/CPB]) hold_err++;
            if (i % CPB == CPB / 2) begin
                check($sformatf("tx_bit%0d", i / CPB), 32'(bus.serial_out), 32'(fr[i/CPB]));
            end
            if (poke && i == 3 * CPB) bus.enable = 1'b1;
            if (poke && i == 3 * CPB + 1) bus.enable = 1'b0;
            @(negedge clk);
        end
        check("tx_hold", 32'(hold_err), 32'd0);
        check("tx_busy_fall", 32'(bus.o_busy), 32'd0);
    endtask

    task automatic drive_rx(input logic [7:0] data, input bit bad_par, input bit bad_stop);
        logic [15:0] fr;
        fr = build_frame({1'b0, data}, 8, 1);
        if (bad_par) fr[9] = ~fr[9];
        if (bad_stop) fr[10] = 1'b0;
        for (int b = 0; b < 11; b++) begin
            tb_rx = fr[b];
            repeat (CPB) @(negedge clk);
        end
        tb_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic expect_rx(input string name, input bit ev, input bit ep, input bit ef,
                             input logic [7:0] data);
        rx_ev_t e;
        check({name, "_events"}, 32'(ev_q.size()), (ev || ep || ef) ? 32'd1 : 32'd0);
        if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            check({name, "_valid"}, 32'(e.valid), 32'(ev));
            check({name, "_perr"}, 32'(e.perr), 32'(ep));
            check({name, "_ferr"}, 32'(e.ferr), 32'(ef));
        end
        if (ev) last_good = data;
        check({name, "_data"}, 32'(bus.received_data), 32'(last_good));
        ev_q.delete();
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        loop_mode = 1'b0;
        tb_rx = 1'b1;
        bus.enable = 1'b0;
        bus.i_data = '0;
        bus2.enable = 1'b0;
        bus2.i_data = '0;
        last_good = '0;
        repeat (3) @(negedge clk);
        check("rst_serial_out", 32'(bus.serial_out), 32'd1);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_valid", 32'(bus.data_is_valid), 32'd0);
        check("rst_perr", 32'(bus.parity_error), 32'd0);
        check("rst_ferr", 32'(bus.framing_error), 32'd0);
        check("rst_rx_data", 32'(bus.received_data), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback frame of A5, then back-to-back frames accepted on the busy-fall cycle.
        loop_mode = 1'b1;
        send_tx(8'hA5, 1'b0);
        expect_rx("loop_a5", 1'b1, 1'b0, 1'b0, 8'hA5);
        send_tx(8'h5A, 1'b0);
        expect_rx("b2b_first", 1'b1, 1'b0, 1'b0, 8'h5A);
        send_tx(8'hC3, 1'b0);
        repeat (2) @(negedge clk);
        expect_rx("b2b_second", 1'b1, 1'b0, 1'b0, 8'hC3);

        // Mid-frame enable must be dropped, not queued.
        send_tx(8'h96, 1'b1);
        repeat (3) @(negedge clk);
        check("poke_no_queue_busy", 32'(bus.o_busy), 32'd0);
        check("poke_no_queue_line", 32'(bus.serial_out), 32'd1);
        expect_rx("poke", 1'b1, 1'b0, 1'b0, 8'h96);

        for (int k = 0; k < 16; k++) begin
            rd = 8'($urandom);
            send_tx(rd, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            expect_rx($sformatf("rand_loop%0d", k), 1'b1, 1'b0, 1'b0, rd);
        end

        // Rx vector table driven directly on serial_in.
        loop_mode = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            drive_rx(vecs[k].data, vecs[k].bad_par, vecs[k].bad_stop);
            expect_rx($sformatf("rx_vec%0d", k), vecs[k].exp_valid, vecs[k].exp_perr,
                      vecs[k].exp_ferr, vecs[k].data);
        end

        // Two-cycle glitch is a false start; the next real frame must still land.
        tb_rx = 1'b0;
        repeat (2) @(negedge clk);
        tb_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        expect_rx("glitch", 1'b0, 1'b0, 1'b0, 8'h00);
        drive_rx(8'h81, 1'b0, 1'b0);
        expect_rx("after_glitch", 1'b1, 1'b0, 1'b0, 8'h81);

        for (int k = 0; k < 12; k++) begin
            rd = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 3) == 0);
            drive_rx(rd, bp, bs);
            expect_rx($sformatf("rand_rx%0d", k), !bp && !bs, bp, bs, rd);
        end

        // Odd parity, 7 data bits, 2 stop bits on the second instance.
        for (int k = 0; k < 2; k++) begin
            d2 = (k == 0) ? 7'h00 : 7'h2A;
            fr2 = build_frame({2'b00, d2}, 7, 2);
            bus2.i_data = d2;
            bus2.enable = 1'b1;
            @(negedge clk);
            bus2.enable = 1'b0;
            hold2 = 0;
            v2 = 0;
            err2 = 0;
            for (int i = 0; i < 11 * CPB; i++) begin
                if (bus2.o_busy !== 1'b1 || bus2.serial_out !== fr2[i/CPB]) hold2++;
                if (i % CPB == CPB / 2) begin
                    check($sformatf("tx2_bit%0d", i / CPB), 32'(bus2.serial_out),
                          32'(fr2[i/CPB]));
                end
                if (bus2.data_is_valid) v2++;
                if (bus2.parity_error || bus2.framing_error) err2++;
                @(negedge clk);
            end
            check("tx2_hold", 32'(hold2), 32'd0);
            check("tx2_busy_fall", 32'(bus2.o_busy), 32'd0);
            check("rx2_valid_count", 32'(v2), 32'd1);
            check("rx2_errors", 32'(err2), 32'd0);
            check("rx2_data", 32'(bus2.received_data), 32'(d2));
        end

        // Reset in the middle of a loopback frame aborts both directions.
        loop_mode = 1'b1;
        ev_q.delete();
        bus.i_data = 8'h69;
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_serial_out", 32'(bus.serial_out), 32'd1);
        check("midrst_busy", 32'(bus.o_busy), 32'd0);
        last_good = '0;
        repeat (12 * CPB) @(negedge clk);
        expect_rx("midrst_abort", 1'b0, 1'b0, 1'b0, 8'h00);
        send_tx(8'h69, 1'b0);
        expect_rx("midrst_next", 1'b1, 1'b0, 1'b0, 8'h69);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
